// File: rtl/read_data_channel_mux.sv
// AXI read-data channel mux: routes one granted slave R channel (of four) to the master named by its RID.
// Define RR_ARB_EN for round-robin arbitration; the default build uses fixed priority (slave 0 highest).
module read_data_channel_mux #(
    parameter int Num_OF_Masters  = 2,
    parameter int Masters_ID_Size = $clog2(Num_OF_Masters),
    parameter int Data_width      = 32,
    parameter int Num_Of_Slaves   = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [Data_width-1:0]      S0_AXI_rdata,
    input  logic [Masters_ID_Size-1:0] S0_AXI_rid,
    input  logic [1:0]                 S0_AXI_rresp,
    input  logic                       S0_AXI_rlast,
    input  logic                       S0_AXI_rvalid,
    output logic                       S0_AXI_rready,
    input  logic [Data_width-1:0]      S1_AXI_rdata,
    input  logic [Masters_ID_Size-1:0] S1_AXI_rid,
    input  logic [1:0]                 S1_AXI_rresp,
    input  logic                       S1_AXI_rlast,
    input  logic                       S1_AXI_rvalid,
    output logic                       S1_AXI_rready,
    input  logic [Data_width-1:0]      S2_AXI_rdata,
    input  logic [Masters_ID_Size-1:0] S2_AXI_rid,
    input  logic [1:0]                 S2_AXI_rresp,
    input  logic                       S2_AXI_rlast,
    input  logic                       S2_AXI_rvalid,
    output logic                       S2_AXI_rready,
    input  logic [Data_width-1:0]      S3_AXI_rdata,
    input  logic [Masters_ID_Size-1:0] S3_AXI_rid,
    input  logic [1:0]                 S3_AXI_rresp,
    input  logic                       S3_AXI_rlast,
    input  logic                       S3_AXI_rvalid,
    output logic                       S3_AXI_rready,
    output logic [Data_width-1:0]      M0_AXI_rdata,
    output logic [1:0]                 M0_AXI_rresp,
    output logic                       M0_AXI_rlast,
    output logic                       M0_AXI_rvalid,
    input  logic                       M0_AXI_rready,
    output logic [Data_width-1:0]      M1_AXI_rdata,
    output logic [1:0]                 M1_AXI_rresp,
    output logic                       M1_AXI_rlast,
    output logic                       M1_AXI_rvalid,
    input  logic                       M1_AXI_rready,
    output logic                       Busy,
    output logic [1:0]                 Granted_Slave
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                     r_state;
    logic [1:0]                 r_grant;
    logic [Masters_ID_Size-1:0] r_rid;
`ifdef RR_ARB_EN
    logic [1:0]                 r_ptr;
`endif

    logic [Data_width-1:0]      w_rdata [4];
    logic [Masters_ID_Size-1:0] w_rid   [4];
    logic [1:0]                 w_rresp [4];
    logic [3:0]                 w_rvalid;
    logic [3:0]                 w_rlast;
    logic [1:0]                 w_sel;
    logic                       w_busy;
    logic                       w_to_m1;
    logic                       w_m0;
    logic                       w_m1;
    logic                       w_rready_routed;
    logic                       w_xfer;

    assign w_rdata  = '{S0_AXI_rdata, S1_AXI_rdata, S2_AXI_rdata, S3_AXI_rdata};
    assign w_rid    = '{S0_AXI_rid, S1_AXI_rid, S2_AXI_rid, S3_AXI_rid};
    assign w_rresp  = '{S0_AXI_rresp, S1_AXI_rresp, S2_AXI_rresp, S3_AXI_rresp};
    assign w_rvalid = {S3_AXI_rvalid, S2_AXI_rvalid, S1_AXI_rvalid, S0_AXI_rvalid};
    assign w_rlast  = {S3_AXI_rlast, S2_AXI_rlast, S1_AXI_rlast, S0_AXI_rlast};

    // Scan from the farthest candidate down so the nearest requester is the last (winning) assignment.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
`ifdef RR_ARB_EN
        w_sel = r_ptr;
        for (int k = Num_Of_Slaves - 1; k >= 0; k--) begin
            if (w_rvalid[r_ptr + 2'(k)]) w_sel = r_ptr + 2'(k);
        end
`else
        w_sel = 2'd0;
        for (int k = Num_Of_Slaves - 1; k >= 0; k--) begin
            if (w_rvalid[k]) w_sel = 2'(k);
        end
`endif
    end

    // Out-of-range RIDs fall through to master 0.
    assign w_busy          = (r_state == BURST);
    assign w_to_m1         = (Num_OF_Masters > 1) && (r_rid == Masters_ID_Size'(1));
    assign w_m0            = w_busy && !w_to_m1;
    assign w_m1            = w_busy && w_to_m1;
    assign w_rready_routed = w_to_m1 ? M1_AXI_rready : M0_AXI_rready;
    assign w_xfer          = w_busy && w_rvalid[r_grant] && w_rready_routed;

    assign M0_AXI_rvalid = w_m0 && w_rvalid[r_grant];
    assign M0_AXI_rlast  = w_m0 && w_rlast[r_grant];
    assign M0_AXI_rdata  = w_m0 ? w_rdata[r_grant] : '0;
    assign M0_AXI_rresp  = w_m0 ? w_rresp[r_grant] : 2'b00;
    assign M1_AXI_rvalid = w_m1 && w_rvalid[r_grant];
    assign M1_AXI_rlast  = w_m1 && w_rlast[r_grant];
    assign M1_AXI_rdata  = w_m1 ? w_rdata[r_grant] : '0;
    assign M1_AXI_rresp  = w_m1 ? w_rresp[r_grant] : 2'b00;

    assign S0_AXI_rready = w_busy && (r_grant == 2'd0) && w_rready_routed;
    assign S1_AXI_rready = w_busy && (r_grant == 2'd1) && w_rready_routed;
    assign S2_AXI_rready = w_busy && (r_grant == 2'd2) && w_rready_routed;
    assign S3_AXI_rready = w_busy && (r_grant == 2'd3) && w_rready_routed;

    assign Busy          = w_busy;
    assign Granted_Slave = r_grant;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_rid   <= '0;
`ifdef RR_ARB_EN
            r_ptr   <= 2'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_rvalid) begin
                        r_grant <= w_sel;
                        r_rid   <= w_rid[w_sel];
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_xfer && w_rlast[r_grant]) begin
                        r_state <= IDLE;
`ifdef RR_ARB_EN
                        r_ptr   <= r_grant + 2'd1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_data_channel_mux.sv
// Directed testbench for read_data_channel_mux (RID widened to 2 bits so an out-of-range ID can be driven).
module tb_read_data_channel_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_rdata  [4];
    logic [1:0]  s_rid    [4];
    logic [1:0]  s_rresp  [4];
    logic [3:0]  s_rlast;
    logic [3:0]  s_rvalid;
    logic [3:0]  s_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
    logic        m0_rready, m1_rready;
    logic        busy;
    logic [1:0]  granted;

    int checks   = 0;
    int failures = 0;
    int xfers;
    logic [1:0] exp_order [3];

    read_data_channel_mux #(
        .Num_OF_Masters (2),
        .Masters_ID_Size(2),
        .Data_width     (32),
        .Num_Of_Slaves  (4)
    ) dut (
        .ACLK         (clk),
        .ARESETN      (rst_n),
        .S0_AXI_rdata (s_rdata[0]), .S0_AXI_rid(s_rid[0]), .S0_AXI_rresp(s_rresp[0]),
        .S0_AXI_rlast (s_rlast[0]), .S0_AXI_rvalid(s_rvalid[0]), .S0_AXI_rready(s_rready[0]),
        .S1_AXI_rdata (s_rdata[1]), .S1_AXI_rid(s_rid[1]), .S1_AXI_rresp(s_rresp[1]),
        .S1_AXI_rlast (s_rlast[1]), .S1_AXI_rvalid(s_rvalid[1]), .S1_AXI_rready(s_rready[1]),
        .S2_AXI_rdata (s_rdata[2]), .S2_AXI_rid(s_rid[2]), .S2_AXI_rresp(s_rresp[2]),
        .S2_AXI_rlast (s_rlast[2]), .S2_AXI_rvalid(s_rvalid[2]), .S2_AXI_rready(s_rready[2]),
        .S3_AXI_rdata (s_rdata[3]), .S3_AXI_rid(s_rid[3]), .S3_AXI_rresp(s_rresp[3]),
        .S3_AXI_rlast (s_rlast[3]), .S3_AXI_rvalid(s_rvalid[3]), .S3_AXI_rready(s_rready[3]),
        .M0_AXI_rdata (m0_rdata), .M0_AXI_rresp(m0_rresp), .M0_AXI_rlast(m0_rlast),
        .M0_AXI_rvalid(m0_rvalid), .M0_AXI_rready(m0_rready),
        .M1_AXI_rdata (m1_rdata), .M1_AXI_rresp(m1_rresp), .M1_AXI_rlast(m1_rlast),
        .M1_AXI_rvalid(m1_rvalid), .M1_AXI_rready(m1_rready),
        .Busy         (busy),
        .Granted_Slave(granted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_rlast   = '0;
        s_rvalid  = '0;
        m0_rready = 1'b0;
        m1_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_rdata[i] = '0;
            s_rid[i]   = '0;
            s_rresp[i] = '0;
        end

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_granted", granted, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_s_rready", s_rready, 0);
        rst_n = 1'b1;

        // Single 4-beat burst S2 -> M1
        s_rvalid[2] = 1'b1;
        s_rid[2]    = 2'd1;
        s_rresp[2]  = 2'b10;
        s_rdata[2]  = 32'hA000_0000;
        m1_rready   = 1'b1;
        #1;
        check("idle_m1_rvalid", m1_rvalid, 0);
        check("idle_s2_rready", s_rready[2], 0);
        tick();
        check("grant_busy", busy, 1);
        check("grant_slave2", granted, 2);
        for (int b = 0; b < 4; b++) begin
            s_rdata[2] = 32'hA000_0000 + 32'(b);
            s_rlast[2] = (b == 3);
            #1;
            check($sformatf("s2_beat%0d_m1_rvalid", b), m1_rvalid, 1);
            check($sformatf("s2_beat%0d_m1_rdata", b), m1_rdata, 32'hA000_0000 + 32'(b));
            check($sformatf("s2_beat%0d_s2_rready", b), s_rready[2], 1);
            check($sformatf("s2_beat%0d_m0_rvalid", b), m0_rvalid, 0);
            tick();
        end
        check("s2_m1_rresp_end", m1_rresp, 0);
        s_rvalid[2] = 1'b0;
        s_rlast[2]  = 1'b0;
        #1;
        check("s2_done_busy", busy, 0);
        check("s2_done_granted_held", granted, 2);
        m1_rready = 1'b0;

        // Back-pressure: 2-beat burst S0 -> M0, ready 1,0,1,0
        xfers       = 0;
        s_rvalid[0] = 1'b1;
        s_rid[0]    = 2'd0;
        s_rdata[0]  = 32'hB000_0000;
        tick();
        check("bp_grant", granted, 0);
        m0_rready = 1'b1;
        #1;
        check("bp_c1_rdata", m0_rdata, 32'hB000_0000);
        check("bp_c1_rready", s_rready[0], 1);
        if (s_rready[0] && s_rvalid[0]) xfers++;
        tick();
        m0_rready  = 1'b0;
        s_rdata[0] = 32'hB000_0001;
        s_rlast[0] = 1'b1;
        #1;
        check("bp_c2_rready", s_rready[0], 0);
        check("bp_c2_rdata", m0_rdata, 32'hB000_0001);
        if (s_rready[0] && s_rvalid[0]) xfers++;
        tick();
        m0_rready = 1'b1;
        #1;
        check("bp_c3_busy_held", busy, 1);
        check("bp_c3_rdata_stable", m0_rdata, 32'hB000_0001);
        check("bp_c3_rlast", m0_rlast, 1);
        if (s_rready[0] && s_rvalid[0]) xfers++;
        tick();
        m0_rready   = 1'b0;
        s_rvalid[0] = 1'b0;
        s_rlast[0]  = 1'b0;
        #1;
        check("bp_c4_busy", busy, 0);
        check("bp_xfer_count", xfers, 2);

        // Bad ID: S1 rid=3 routes to M0, single beat
        s_rvalid[1] = 1'b1;
        s_rid[1]    = 2'd3;
        s_rlast[1]  = 1'b1;
        s_rdata[1]  = 32'hC0C0_C0C0;
        m0_rready   = 1'b1;
        m1_rready   = 1'b1;
        tick();
        check("badid_m0_rvalid", m0_rvalid, 1);
        check("badid_m0_rdata", m0_rdata, 32'hC0C0_C0C0);
        check("badid_m1_rvalid", m1_rvalid, 0);
        check("badid_s1_rready", s_rready[1], 1);
        tick();
        s_rvalid[1] = 1'b0;
        s_rlast[1]  = 1'b0;
        #1;
        check("badid_done_busy", busy, 0);

        // RID change mid-burst is ignored
        s_rvalid[3] = 1'b1;
        s_rid[3]    = 2'd0;
        s_rdata[3]  = 32'hD000_0000;
        m0_rready   = 1'b0;
        tick();
        s_rid[3] = 2'd1;
        #1;
        check("ridchg_m0_rvalid", m0_rvalid, 1);
        check("ridchg_m1_rvalid", m1_rvalid, 0);
        m0_rready  = 1'b1;
        s_rlast[3] = 1'b1;
        tick();
        s_rvalid[3] = 1'b0;
        s_rlast[3]  = 1'b0;
        s_rid[3]    = 2'd0;
        #1;
        check("ridchg_done_busy", busy, 0);

        // Contention S0 + S3, single-beat bursts, both requesting throughout
`ifdef RR_ARB_EN
        exp_order = '{2'd0, 2'd3, 2'd0};
`else
        exp_order = '{2'd0, 2'd0, 2'd0};
`endif
        s_rvalid[0] = 1'b1;
        s_rvalid[3] = 1'b1;
        s_rlast[0]  = 1'b1;
        s_rlast[3]  = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();
            check($sformatf("cont03_grant%0d", g), granted, exp_order[g]);
            check($sformatf("cont03_busy%0d", g), busy, 1);
            tick();
            check($sformatf("cont03_idle%0d", g), busy, 0);
        end
        s_rvalid = '0;
        s_rlast  = '0;

`ifndef RR_ARB_EN
        // Fixed priority: S1 always beats S2
        s_rvalid[1] = 1'b1;
        s_rvalid[2] = 1'b1;
        s_rid[1]    = 2'd0;
        s_rid[2]    = 2'd0;
        s_rlast[1]  = 1'b1;
        s_rlast[2]  = 1'b1;
        for (int g = 0; g < 2; g++) begin
            tick();
            check($sformatf("fp12_grant%0d", g), granted, 1);
            tick();
        end
        s_rvalid[1] = 1'b0;
        tick();
        check("fp12_grant_s2", granted, 2);
        tick();
        s_rvalid = '0;
        s_rlast  = '0;
`endif

        // Reset mid-burst (beat 2 of 4), then re-arbitration
        s_rvalid[2] = 1'b1;
        s_rid[2]    = 2'd1;
        s_rdata[2]  = 32'hE000_0000;
        m1_rready   = 1'b1;
        tick();
        check("rstmid_grant", granted, 2);
        tick();
        s_rdata[2] = 32'hE000_0001;
        #1;
        check("rstmid_beat2_m1_rvalid", m1_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_m1_rvalid", m1_rvalid, 0);
        check("rstmid_m1_rdata", m1_rdata, 0);
        check("rstmid_s2_rready", s_rready[2], 0);
        check("rstmid_granted", granted, 0);
        s_rvalid[2] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rstrel_idle", busy, 0);
        s_rvalid[2] = 1'b1;
        #1;
        check("rstrel_pre_grant", busy, 0);
        tick();
        check("rstrel_busy", busy, 1);
        check("rstrel_granted", granted, 2);
        check("rstrel_m1_rdata", m1_rdata, 32'hE000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_data_channel_mux.md
READ_DATA_CHANNEL_MUX -- requirements
Module: read_data_channel_mux

Interface
REQ-001 Parameter Num_OF_Masters, default 2, number of masters served.
REQ-002 Parameter Masters_ID_Size, default $clog2(Num_OF_Masters), RID width carrying the master index.
REQ-003 Parameter Data_width, default 32, RDATA width.
REQ-004 Parameter Num_Of_Slaves, default 4, number of slave ports; the port list is fixed at 4 slaves.
REQ-005 ACLK  input  1  single clock; all state updates on the rising edge.
REQ-006 ARESETN  input  1  reset, asynchronous, active-low.
REQ-007 Sn_AXI_rdata (n=0..3)  input  Data_width  read data from slave n.
REQ-008 Sn_AXI_rid (n=0..3)  input  Masters_ID_Size  index of the destination master.
REQ-009 Sn_AXI_rresp (n=0..3)  input  2  read response.
REQ-010 Sn_AXI_rlast (n=0..3)  input  1  last beat of burst.
REQ-011 Sn_AXI_rvalid (n=0..3)  input  1  beat valid.
REQ-012 Sn_AXI_rready (n=0..3)  output  1  beat accepted by the interconnect.
REQ-013 Mm_AXI_rdata/rresp/rlast/rvalid (m=0..1)  output  Data_width/2/1/1  routed R channel to master m.
REQ-014 Mm_AXI_rready (m=0..1)  input  1  master m ready.
REQ-015 Busy  output  1  high while a burst is granted.
REQ-016 Granted_Slave  output  2  index of the granted slave, valid when Busy=1.

Function
REQ-017 FSM states: IDLE and BURST.
REQ-018 IDLE: no Sn_AXI_rready and no Mm_AXI_rvalid asserted.
REQ-019 IDLE: if any Sn_AXI_rvalid=1, the arbiter selects one slave, registers its index and RID, and moves to BURST on the next edge; arbitration latency is 1 cycle.
REQ-020 BURST: the granted slave's rdata/rresp/rlast/rvalid drive master m = registered RID, combinationally; the other master's rvalid=0 and its data outputs=0.
REQ-021 BURST: the granted slave's rready equals Mm_AXI_rready of the routed master; all other Sn_AXI_rready=0.
REQ-022 A beat transfers when the granted rvalid and rready are both 1; the grant holds through back-pressure, with no re-arbitration mid-burst.
REQ-023 A beat transfer with rlast=1 returns the FSM to IDLE on that edge; the next grant comes no earlier than 1 cycle later.
REQ-024 A single-beat burst (rlast on the first beat) is legal: IDLE -> BURST -> IDLE.
REQ-025 RID is sampled only at grant; an RID change by the slave mid-burst is ignored.
REQ-026 An RID >= Num_OF_Masters routes to master 0.
REQ-027 Busy=1 exactly in BURST; Granted_Slave holds its last value in IDLE.

Reset
REQ-028 ARESETN=0 forces IDLE, grant index 0, RID register 0, arbitration pointer 0, and all rvalid, rready, rdata, rresp, rlast and Busy outputs to 0, without waiting for a clock edge.
REQ-029 A reset asserted mid-burst abandons the burst; after release the FSM starts in IDLE and re-arbitrates.

Configuration
REQ-030 Macro RR_ARB_EN defined: round-robin arbitration; the search starts at (last granted + 1) mod 4, and the pointer updates on rlast completion.
REQ-031 RR_ARB_EN undefined: fixed priority, slave 0 highest and slave 3 lowest; there is no pointer register.

Verification
REQ-032 Single burst: S2 rvalid with rid=1 and 4 beats (rlast on beat 4), M1 rready=1 -> M1 receives 4 beats in consecutive cycles after a 1-cycle grant, S2 rready mirrors M1 rready, M0 rvalid stays 0.
REQ-033 Back-pressure: M0 rready toggles 1,0,1,0 during a 2-beat burst from S0 -> rdata stable while stalled, grant held, exactly 2 transfers.
REQ-034 Contention with RR_ARB_EN: S0 and S3 both rvalid with 1-beat bursts, pointer=0 -> grant order S0 then S3; repeat with S0 re-requesting -> S3 is granted before S0.
REQ-035 Contention without RR_ARB_EN: S1 and S2 both continuously rvalid -> S1 is always granted first.
REQ-036 Reset mid-burst: ARESETN low at beat 2 of 4 -> all outputs 0 immediately, Busy=0; after release a new grant occurs 1 cycle after rvalid.
REQ-037 Bad ID: S1 rid=3 with Num_OF_Masters=2 -> the burst is delivered on M0.
